divider_seq: RTL and testbench

DIVIDER_SEQ -- requirements
Module: divider_seq

---
 rtl/divider_seq_if.sv | 24 ++
 rtl/divider_seq.sv | 123 ++++++++++++
 tb/tb_divider_seq.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/divider_seq_if.sv
// divider_seq_if: request/response bundle for the sequential divider.
// master drives requests and observes results; slave is the divider itself.
interface divider_seq_if #(
  parameter int unsigned WIDTH = 4
) ();
  logic                 in_valid;
  logic [2*WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]     divisor;
  logic                 in_ready;
  logic [2*WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]     remainder;
  logic                 div_by_zero;
  logic                 out_valid;

  modport master (
    output in_valid, dividend, divisor,
    input  in_ready, quotient, remainder, div_by_zero, out_valid
  );

  modport slave (
    input  in_valid, dividend, divisor,
    output in_ready, quotient, remainder, div_by_zero, out_valid
  );
endinterface

// File: rtl/divider_seq.sv
// divider_seq: restoring shift-subtract unsigned divider, 2*WIDTH-bit dividend
// by WIDTH-bit divisor, one quotient bit per cycle, MSB first.
// Divide-by-zero completes immediately with quotient all ones.
// Optional macro EARLY_EXIT_EN: finish immediately when dividend < divisor.
module divider_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  divider_seq_if.slave bus
);
  localparam int unsigned     DW   = 2 * WIDTH;
  localparam int unsigned     CW   = $clog2(DW) + 1;
  localparam logic [CW-1:0]   LAST = CW'(DW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [DW-1:0]    r_dvd;
  logic [DW-1:0]    r_quot;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic [CW-1:0]    r_cnt;
  logic             r_dbz;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_zero;
  logic             w_short;
  logic             w_ge;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_diff;

  assign w_zero = (bus.divisor == '0);

`ifdef EARLY_EXIT_EN
  // dividend == 0 is covered since a non-zero divisor is strictly greater
  assign w_short = !w_zero && (bus.dividend < {{WIDTH{1'b0}}, bus.divisor});
`else
  assign w_short = 1'b0;
`endif

  // The stored remainder is always < divisor, so only the shifted trial value
  // needs the extra bit; the subtract result always fits back in WIDTH bits.
  assign w_trial = {r_rem, r_dvd[DW-1]};
  assign w_ge    = (w_trial >= {1'b0, r_dvs});
  assign w_diff  = w_trial[WIDTH-1:0] - r_dvs;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state and handshake outputs
  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_next = (w_zero || w_short) ? DONE : CALC;
      end
      CALC: if (r_cnt == LAST) w_next = DONE;
      DONE: begin
        w_out_valid = 1'b1;
        w_next      = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand capture and one restoring step per CALC cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvd  <= '0;
      r_dvs  <= '0;
      r_quot <= '0;
      r_rem  <= '0;
      r_cnt  <= '0;
      r_dbz  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: if (bus.in_valid) begin
          r_dvd <= bus.dividend;
          r_dvs <= bus.divisor;
          r_cnt <= '0;
          r_dbz <= w_zero;
          if (w_zero) begin
            r_quot <= '1;
            r_rem  <= bus.dividend[WIDTH-1:0];
          end else if (w_short) begin
            r_quot <= '0;
            r_rem  <= bus.dividend[WIDTH-1:0];
          end else begin
            r_quot <= '0;
            r_rem  <= '0;
          end
        end
        CALC: begin
          r_rem  <= w_ge ? w_diff : w_trial[WIDTH-1:0];
          r_quot <= {r_quot[DW-2:0], w_ge};
          r_dvd  <= r_dvd << 1;
          r_cnt  <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = w_out_valid;
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_rem;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_divider_seq.sv
// tb_divider_seq: scoreboard bench for divider_seq at WIDTH=4.
// Define EARLY_EXIT_EN for both RTL and bench to check the early-exit build.
module tb_divider_seq;
  localparam int unsigned W = 4;

  typedef struct {
    logic [7:0]  q;
    logic [3:0]  r;
    logic        dbz;
    int unsigned lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  divider_seq_if #(.WIDTH(W)) bus ();

  divider_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference behaviour; latency counts the cycle right after acceptance as 1
  function automatic exp_t model(input logic [7:0] a, input logic [3:0] b);
    exp_t e;
    if (b == 4'd0) begin
      e.q = 8'hFF; e.r = a[3:0]; e.dbz = 1'b1; e.lat = 1;
    end else begin
      e.q   = a / {4'd0, b};
      e.r   = 4'(a % {4'd0, b});
      e.dbz = 1'b0;
      e.lat = 9;
`ifdef EARLY_EXIT_EN
      if (a < {4'd0, b}) e.lat = 1;
`endif
    end
    return e;
  endfunction

  function automatic exp_t mk(input logic [7:0] q, input logic [3:0] r,
                              input logic dbz, input int unsigned lat);
    exp_t e;
    e.q = q; e.r = r; e.dbz = dbz; e.lat = lat;
    return e;
  endfunction

  task automatic run_op(input logic [7:0] a, input logic [3:0] b, input exp_t e,
                        input string tag);
    int unsigned lat;
    exp_t x;
    sb.push_back(e);
    @(negedge clk);
    n_vec++;
    if (bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL %s in_ready_idle: got %b want 1", tag, bus.in_ready);
    end
    bus.in_valid = 1'b1; bus.dividend = a; bus.divisor = b;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0; bus.dividend = ~a; bus.divisor = ~b;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    x = sb.pop_front();
    n_vec++;
    if (lat != x.lat) begin
      n_err++; $display("FAIL %s latency: got %0d want %0d", tag, lat, x.lat);
    end
    n_vec++;
    if (bus.quotient !== x.q) begin
      n_err++; $display("FAIL %s quotient: got %0d want %0d", tag, bus.quotient, x.q);
    end
    n_vec++;
    if (bus.remainder !== x.r) begin
      n_err++; $display("FAIL %s remainder: got %0d want %0d", tag, bus.remainder, x.r);
    end
    n_vec++;
    if (bus.div_by_zero !== x.dbz) begin
      n_err++; $display("FAIL %s div_by_zero: got %b want %b", tag, bus.div_by_zero, x.dbz);
    end
    @(negedge clk);
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL %s after_done: out_valid %b in_ready %b want 0 1",
                        tag, bus.out_valid, bus.in_ready);
    end
    n_vec++;
    if (bus.quotient !== x.q || bus.remainder !== x.r || bus.div_by_zero !== x.dbz) begin
      n_err++; $display("FAIL %s hold: got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b", tag,
                        bus.quotient, bus.remainder, bus.div_by_zero, x.q, x.r, x.dbz);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.dividend = '0; bus.divisor = '0;
    #12;
    n_vec++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.quotient !== 8'd0 ||
        bus.remainder !== 4'd0 || bus.div_by_zero !== 1'b0) begin
      n_err++; $display("FAIL reset_state: rdy=%b ov=%b q=%0d r=%0d z=%b want 1 0 0 0 0",
                        bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_release_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_spec_vectors;
    run_op(8'd100, 4'd7,  mk(8'd14,  4'd2, 1'b0, 9), "100/7");
    run_op(8'd255, 4'd1,  mk(8'd255, 4'd0, 1'b0, 9), "255/1");
    run_op(8'd255, 4'd15, mk(8'd17,  4'd0, 1'b0, 9), "255/15");
`ifdef EARLY_EXIT_EN
    run_op(8'd5,   4'd9,  mk(8'd0,   4'd5, 1'b0, 1), "5/9");
    run_op(8'd0,   4'd3,  mk(8'd0,   4'd0, 1'b0, 1), "0/3");
`else
    run_op(8'd5,   4'd9,  mk(8'd0,   4'd5, 1'b0, 9), "5/9");
    run_op(8'd0,   4'd3,  mk(8'd0,   4'd0, 1'b0, 9), "0/3");
`endif
    run_op(8'd15,  4'd15, mk(8'd1,   4'd0, 1'b0, 9), "15/15");
  endtask

  task automatic test_div_zero;
    run_op(8'd37,  4'd0, mk(8'hFF, 4'd5,  1'b1, 1), "37/0");
    run_op(8'd250, 4'd0, mk(8'hFF, 4'd10, 1'b1, 1), "250/0");
  endtask

  task automatic test_random;
    logic [7:0] a;
    logic [3:0] b;
    for (int i = 0; i < 8; i++) begin
      a = 8'($urandom);
      b = 4'($urandom_range(1, 15));
      run_op(a, b, model(a, b), "random");
    end
  endtask

  task automatic test_mid_reset;
    bit seen = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.dividend = 8'd100; bus.divisor = 4'd7;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.quotient !== 8'd0 ||
        bus.remainder !== 4'd0 || bus.div_by_zero !== 1'b0) begin
      n_err++; $display("FAIL mid_reset_state: rdy=%b ov=%b q=%0d r=%0d z=%b want 1 0 0 0 0",
                        bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (seen) begin
      n_err++; $display("FAIL mid_reset_no_out_valid: got out_valid pulse want none");
    end
    run_op(8'd100, 4'd7, mk(8'd14, 4'd2, 1'b0, 9), "100/7_after_reset");
  endtask

  // in_valid held high; bench tracks when the DUT must be idle and accept
  task automatic test_back_to_back;
    bit          exp_idle = 1'b1;
    int unsigned cyc = 0;
    int unsigned done_cnt = 0;
    int unsigned guard = 0;
    logic [7:0]  a;
    logic [3:0]  b;
    exp_t        x;
    @(negedge clk);
    while (done_cnt < 5 && guard < 150) begin
      a = 8'($urandom);
      b = 4'($urandom_range(0, 15));
      bus.in_valid = 1'b1; bus.dividend = a; bus.divisor = b;
      if (exp_idle) begin
        n_vec++;
        if (bus.in_ready !== 1'b1) begin
          n_err++; $display("FAIL b2b in_ready: got %b want 1 (cycle %0d)", bus.in_ready, guard);
        end
        sb.push_back(model(a, b));
        exp_idle = 1'b0;
        cyc = 0;
      end else begin
        x = sb[0];
        n_vec++;
        if (bus.in_ready !== 1'b0) begin
          n_err++; $display("FAIL b2b in_ready_busy: got %b want 0 (cycle %0d)", bus.in_ready, cyc);
        end
        if (cyc == x.lat) begin
          n_vec++;
          if (bus.out_valid !== 1'b1 || bus.quotient !== x.q || bus.remainder !== x.r ||
              bus.div_by_zero !== x.dbz) begin
            n_err++; $display("FAIL b2b result: got ov=%b q=%0d r=%0d z=%b want 1 %0d %0d %b",
                              bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero,
                              x.q, x.r, x.dbz);
          end
          void'(sb.pop_front());
          done_cnt++;
          exp_idle = 1'b1;
        end else begin
          n_vec++;
          if (bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL b2b early_out_valid: got 1 want 0 (cycle %0d)", cyc);
          end
        end
      end
      @(negedge clk);
      cyc++;
      guard++;
    end
    bus.in_valid = 1'b0;
    n_vec++;
    if (done_cnt != 5) begin
      n_err++; $display("FAIL b2b completions: got %0d want 5", done_cnt);
    end
    repeat (12) @(negedge clk);
    sb.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_spec_vectors();
    test_div_zero();
    test_random();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
